// File: rtl/tc_pix_capture.sv
// Pixel capture for the focal-plane readout: tags ADC words with (x, y, SOF/EOL/EOF) from the
// timing-controller strobes and queues them in a small FIFO with overflow and frame-fault flags.
module tc_pix_capture #(
  parameter int COLS       = 320,
  parameter int ROWS       = 240,
  parameter int ADC_W      = 14,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             f_sync,
  input  logic             dr,
  input  logic             sample,
  input  logic             integ,
  input  logic [ADC_W-1:0] adc_data,
  input  logic             out_ready,
  output logic             pix_valid,
  output logic [ADC_W-1:0] pix_data,
  output logic [8:0]       pix_x,
  output logic [7:0]       pix_y,
  output logic             pix_sof,
  output logic             pix_eol,
  output logic             pix_eof,
  output logic             ovf,
  output logic             frame_err
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int EW = ADC_W + 9 + 8 + 3;
  localparam logic [8:0]  X_LAST = 9'(COLS - 1);
  localparam logic [7:0]  Y_LAST = 8'(ROWS - 1);
  localparam logic [8:0]  Y_LIM  = 9'(ROWS);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT_ROW, ROW, ROW_END} state_t;

  state_t state;

  logic             f_sync_p0, f_sync_p1;
  logic             dr_p0, dr_p1;
  logic             sample_p0, sample_p1;
  logic             integ_p0;
  logic [ADC_W-1:0] adc_p0;

  logic [8:0]       x;
  logic [7:0]       y;

  logic             vld_p2;
  logic [ADC_W-1:0] data_p2;
  logic [8:0]       x_p2;
  logic [7:0]       y_p2;
  logic             sof_p2, eol_p2, eof_p2;

  logic [EW-1:0]    mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic [EW-1:0]    head;

  logic fs_rise, dr_rise, dr_fall, smp_fall;
  logic full, pop, push;

  assign fs_rise  = f_sync_p0 & ~f_sync_p1;
  assign dr_rise  = dr_p0 & ~dr_p1;
  assign dr_fall  = ~dr_p0 & dr_p1;
  assign smp_fall = ~sample_p0 & sample_p1;

  assign full      = (count == FULL_CNT);
  assign pix_valid = (count != '0);
  assign pop       = pix_valid & out_ready;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign push      = vld_p2 & (~full | pop);

  // Stage p0/p1: input registration and edge history; FSM and counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_sync_p0 <= 1'b0;
      f_sync_p1 <= 1'b0;
      dr_p0     <= 1'b0;
      dr_p1     <= 1'b0;
      sample_p0 <= 1'b0;
      sample_p1 <= 1'b0;
      integ_p0  <= 1'b0;
      state     <= IDLE;
      x         <= '0;
      y         <= '0;
      vld_p2    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      f_sync_p0 <= f_sync;
      f_sync_p1 <= f_sync_p0;
      dr_p0     <= dr;
      dr_p1     <= dr_p0;
      sample_p0 <= sample;
      sample_p1 <= sample_p0;
      integ_p0  <= integ;
      vld_p2    <= 1'b0;
      frame_err <= 1'b0;
      if (fs_rise) begin
        x     <= '0;
        y     <= '0;
        state <= WAIT_ROW;
        if (state != IDLE) frame_err <= 1'b1;
      end else begin
        case (state)
          WAIT_ROW: begin
            if (dr_rise && ({1'b0, y} < Y_LIM)) begin
              x     <= '0;
              state <= ROW;
            end
          end
          ROW: begin
            // Readout window closed before the row was complete.
            if (dr_fall) begin
              frame_err <= 1'b1;
              if (y == Y_LAST) state <= IDLE;
              else begin
                y     <= y + 8'd1;
                state <= WAIT_ROW;
              end
            end else if (smp_fall && !integ_p0) begin
              vld_p2 <= 1'b1;
              x      <= x + 9'd1;
              if (x == X_LAST) state <= ROW_END;
            end
          end
          ROW_END: begin
            if (dr_fall) begin
              if (y == Y_LAST) state <= IDLE;
              else begin
                y     <= y + 8'd1;
                state <= WAIT_ROW;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Stage p2: captured pixel and tags, computed from pre-increment counters
  always_ff @(posedge clk) begin
    adc_p0  <= adc_data;
    data_p2 <= adc_p0;
    x_p2    <= x;
    y_p2    <= y;
    sof_p2  <= (x == '0) && (y == '0);
    eol_p2  <= (x == X_LAST);
    eof_p2  <= (x == X_LAST) && (y == Y_LAST);
  end

  // Stage p3: output FIFO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (fs_rise) ovf <= 1'b0;
      if (vld_p2 && full && !pop) ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {data_p2, x_p2, y_p2, sof_p2, eol_p2, eof_p2};
  end

  assign head = pix_valid ? mem[rd_ptr] : '0;
  assign {pix_data, pix_x, pix_y, pix_sof, pix_eol, pix_eof} = head;

endmodule

// File: tb/tb_tc_pix_capture.sv
// Directed bench for tc_pix_capture on a 4x3 frame with an 8-entry FIFO.
module tb_tc_pix_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        f_sync = 1'b0;
  logic        dr = 1'b0;
  logic        sample = 1'b1;
  logic        integ = 1'b0;
  logic [13:0] adc_data = '0;
  logic        out_ready = 1'b1;
  logic        pix_valid;
  logic [13:0] pix_data;
  logic [8:0]  pix_x;
  logic [7:0]  pix_y;
  logic        pix_sof, pix_eol, pix_eof;
  logic        ovf, frame_err;

  int n_chk = 0;
  int n_err = 0;
  int err_pulses = 0;
  int pops = 0;
  int base_err, base_pops;
  logic [33:0] exp_q[$];

  tc_pix_capture #(.COLS(4), .ROWS(3), .ADC_W(14), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .f_sync(f_sync), .dr(dr), .sample(sample), .integ(integ),
    .adc_data(adc_data), .out_ready(out_ready), .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_x(pix_x), .pix_y(pix_y), .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_eof(pix_eof),
    .ovf(ovf), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [33:0] got, input logic [33:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [33:0] ent(input int d, input int px, input int py,
                                      input bit sof, input bit eol, input bit eof);
    return {14'(d), 9'(px), 8'(py), sof, eol, eof};
  endfunction

  always @(negedge clk) begin
    if (frame_err) err_pulses++;
    if (pix_valid && out_ready && !rst) begin
      pops++;
      if (exp_q.size() == 0) check("unexpected_pop", 34'(1), 34'(0));
      else check("pix", {pix_data, pix_x, pix_y, pix_sof, pix_eol, pix_eof}, exp_q.pop_front());
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic fsync();
    f_sync = 1'b1; cyc(3);
    f_sync = 1'b0; cyc(3);
  endtask

  task automatic row_begin();
    dr = 1'b1; cyc(3);
  endtask

  task automatic row_end();
    dr = 1'b0; cyc(3);
  endtask

  task automatic pixel(input int d);
    adc_data = 14'(d);
    sample = 1'b0; cyc(2);
    sample = 1'b1; cyc(2);
  endtask

  task automatic frame(input int base, input int limit);
    fsync();
    for (int r = 0; r < 3; r++) begin
      row_begin();
      for (int c = 0; c < 4; c++) begin
        int k;
        k = r * 4 + c;
        if (k < limit) exp_q.push_back(ent(base + k, c, r, k == 0, c == 3, k == 11));
        pixel(base + k);
      end
      row_end();
    end
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 80) begin
      cyc(1);
      t++;
    end
    cyc(4);
    check(tag, 34'(exp_q.size()), 34'(0));
  endtask

  initial begin
    cyc(3);
    check("rst_valid", 34'(pix_valid), 34'(0));
    check("rst_ovf", 34'(ovf), 34'(0));
    check("rst_ferr", 34'(frame_err), 34'(0));
    check("rst_data", 34'(pix_data), 34'(0));
    rst = 1'b0;
    cyc(3);

    // 1: full frame, downstream always ready
    base_err = err_pulses;
    frame(0, 12);
    drain("t1_drain");
    check("t1_ferr", 34'(err_pulses - base_err), 34'(0));
    check("t1_ovf", 34'(ovf), 34'(0));

    // 2: stalled downstream overflows after 8 entries
    out_ready = 1'b0;
    base_pops = pops;
    frame(100, 8);
    cyc(3);
    check("t2_ovf", 34'(ovf), 34'(1));
    check("t2_valid", 34'(pix_valid), 34'(1));
    check("t2_head", 34'(pix_data), 34'(100));
    cyc(5);
    check("t2_hold", 34'(pix_data), 34'(100));
    out_ready = 1'b1;
    drain("t2_drain");
    check("t2_pops", 34'(pops - base_pops), 34'(8));
    check("t2_ovf_sticky", 34'(ovf), 34'(1));

    // 3: short row 1
    base_err = err_pulses;
    fsync();
    check("t3_ovf_clr", 34'(ovf), 34'(0));
    row_begin();
    for (int c = 0; c < 4; c++) begin
      exp_q.push_back(ent(300 + c, c, 0, c == 0, c == 3, 1'b0));
      pixel(300 + c);
    end
    row_end();
    row_begin();
    for (int c = 0; c < 2; c++) begin
      exp_q.push_back(ent(310 + c, c, 1, 1'b0, 1'b0, 1'b0));
      pixel(310 + c);
    end
    row_end();
    check("t3_ferr", 34'(err_pulses - base_err), 34'(1));
    row_begin();
    for (int c = 0; c < 4; c++) begin
      exp_q.push_back(ent(320 + c, c, 2, 1'b0, c == 3, c == 3));
      pixel(320 + c);
    end
    row_end();
    drain("t3_drain");

    // 4: frame restart mid-row
    base_err = err_pulses;
    fsync();
    row_begin();
    for (int c = 0; c < 4; c++) begin
      exp_q.push_back(ent(400 + c, c, 0, c == 0, c == 3, 1'b0));
      pixel(400 + c);
    end
    row_end();
    row_begin();
    for (int c = 0; c < 2; c++) begin
      exp_q.push_back(ent(410 + c, c, 1, 1'b0, 1'b0, 1'b0));
      pixel(410 + c);
    end
    fsync();
    check("t4_ferr", 34'(err_pulses - base_err), 34'(1));
    row_end();
    row_begin();
    exp_q.push_back(ent(420, 0, 0, 1'b1, 1'b0, 1'b0));
    pixel(420);

    // 5: sample during integration is ignored
    integ = 1'b1; cyc(2);
    pixel(500);
    integ = 1'b0; cyc(2);
    exp_q.push_back(ent(501, 1, 0, 1'b0, 1'b0, 1'b0));
    pixel(501);
    drain("t5_drain");
    check("t5_ferr", 34'(err_pulses - base_err), 34'(1));

    // 6: reset with 5 entries queued
    out_ready = 1'b0;
    base_err = err_pulses;
    row_end();
    fsync();
    check("t6_ferr", 34'(err_pulses - base_err), 34'(2));
    row_begin();
    for (int c = 0; c < 4; c++) pixel(600 + c);
    row_end();
    row_begin();
    pixel(604);
    cyc(3);
    check("t6_valid_pre", 34'(pix_valid), 34'(1));
    base_err = err_pulses;
    rst = 1'b1;
    #1;
    check("t6_valid_rst", 34'(pix_valid), 34'(0));
    check("t6_ovf_rst", 34'(ovf), 34'(0));
    dr = 1'b0;
    cyc(2);
    rst = 1'b0;
    out_ready = 1'b1;
    cyc(3);
    check("t6_valid_post", 34'(pix_valid), 34'(0));
    frame(700, 12);
    drain("t6_drain");
    check("t6_ferr_post", 34'(err_pulses - base_err), 34'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
